// File: rtl/regfile_access_arbiter_if.sv
// Host-request, response and register-file port bundle of the register-file access arbiter.
// The master side is the requesters plus the register file; the slave side is the arbiter.
interface regfile_access_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        rf_write;
    logic        rf_read;
    logic [7:0]  rf_write_addr;
    logic [7:0]  rf_write_data;
    logic [7:0]  rf_read_addr;
    logic [7:0]  rf_read_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rf_read_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rf_read_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter that shares the register-file port pair between two requesters,
// running one IDLE -> ISSUE -> WAIT -> RESP transaction at a time.
module regfile_access_arbiter #(
    parameter int NUMREGS = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_LIMIT = 8'(NUMREGS);

    state_t      state_r;
    logic        rr_last_r;
    logic        own_r;
    logic        wr_r;
    logic        err_r;
    logic        rf_write_r;
    logic        rf_read_r;
    logic [7:0]  rf_write_addr_r;
    logic [7:0]  rf_write_data_r;
    logic [7:0]  rf_read_addr_r;
    logic [1:0]  rsp_valid_r;
    logic        rsp_err_r;
    logic [7:0]  rsp_rdata_r;

    logic        grant_s;
    logic [1:0]  ready_s;
    logic        accept_s;
    logic        sel_write_s;
    logic [7:0]  sel_addr_s;
    logic [7:0]  sel_wdata_s;
    logic        sel_range_ok_s;

    // Grant selection and combinational ready for the granted requester in IDLE.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~rr_last_r;
            default: grant_s = 1'b0;
        endcase

        ready_s = 2'b00;
        if (state_r == ST_IDLE && bus.req_valid != 2'b00) begin
            ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            ready_s = 2'b00;
        end

        accept_s       = |(bus.req_valid & ready_s);
        sel_write_s    = grant_s ? bus.req_write[1]    : bus.req_write[0];
        sel_addr_s     = grant_s ? bus.req_addr[15:8]  : bus.req_addr[7:0];
        sel_wdata_s    = grant_s ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
        sel_range_ok_s = (sel_addr_s < ADDR_LIMIT);
    end

    // Transaction FSM; strobes and address outputs are loaded on accept so they are live in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            rr_last_r       <= 1'b1;
            own_r           <= 1'b0;
            wr_r            <= 1'b0;
            err_r           <= 1'b0;
            rf_write_r      <= 1'b0;
            rf_read_r       <= 1'b0;
            rf_write_addr_r <= 8'h00;
            rf_write_data_r <= 8'h00;
            rf_read_addr_r  <= 8'h00;
            rsp_valid_r     <= 2'b00;
            rsp_err_r       <= 1'b0;
            rsp_rdata_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        own_r     <= grant_s;
                        wr_r      <= sel_write_s;
                        err_r     <= ~sel_range_ok_s;
                        rr_last_r <= grant_s;
                        if (sel_range_ok_s && sel_write_s) begin
                            rf_write_r      <= 1'b1;
                            rf_write_addr_r <= sel_addr_s;
                            rf_write_data_r <= sel_wdata_s;
                        end else if (sel_range_ok_s) begin
                            rf_read_r      <= 1'b1;
                            rf_read_addr_r <= sel_addr_s;
                        end else begin
                            rf_write_r <= 1'b0;
                            rf_read_r  <= 1'b0;
                        end
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    rf_write_r <= 1'b0;
                    rf_read_r  <= 1'b0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Regfile readback arrives one cycle after the read strobe.
                    rsp_rdata_r <= (!wr_r && !err_r) ? bus.rf_read_data : 8'h00;
                    rsp_valid_r <= own_r ? 2'b10 : 2'b01;
                    rsp_err_r   <= err_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_r <= 2'b00;
                    rsp_err_r   <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = ready_s;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_err       = rsp_err_r;
    assign bus.rsp_rdata     = rsp_rdata_r;
    assign bus.rf_write      = rf_write_r;
    assign bus.rf_read       = rf_read_r;
    assign bus.rf_write_addr = rf_write_addr_r;
    assign bus.rf_write_data = rf_write_data_r;
    assign bus.rf_read_addr  = rf_read_addr_r;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a small 1-cycle-latency register-file model.
module tb_regfile_access_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n_rsp0 = 0;
    int   n_rsp1 = 0;
    int   n_wr   = 0;
    int   n_rd   = 0;
    int   snap_a;
    int   snap_b;
    int   snap_c;
    logic [7:0] regs [0:15] = '{default: 8'h00};

    regfile_access_arbiter_if bus ();

    regfile_access_arbiter #(.NUMREGS(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: registered readback, one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rf_write) regs[bus.rf_write_addr[3:0]] <= bus.rf_write_data;
        if (bus.rf_read)  bus.rf_read_data <= regs[bus.rf_read_addr[3:0]];
    end

    // Event counters for responses and strobes.
    always @(posedge clk) begin
        if (bus.rsp_valid[0]) n_rsp0 <= n_rsp0 + 1;
        if (bus.rsp_valid[1]) n_rsp1 <= n_rsp1 + 1;
        if (bus.rf_write)     n_wr   <= n_wr + 1;
        if (bus.rf_read)      n_rd   <= n_rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [15:0] a, input logic [15:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("rst_ready",     32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_outs", {bus.rsp_err, bus.rf_write, bus.rf_read, bus.rsp_rdata,
                         bus.rf_write_addr, bus.rf_write_data}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: req0 write 0x03 <- 0xA5
        drive(2'b01, 2'b01, 16'h0003, 16'h00A5);
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t1_ready_busy", 32'(bus.req_ready), 32'h0);
        chk("t1_strobe", {bus.rf_write, bus.rf_read, bus.rf_write_addr, bus.rf_write_data},
            {2'b10, 8'h03, 8'hA5});
        tick();
        chk("t1_strobe_off", 32'(bus.rf_write), 32'h0);
        tick();
        chk("t1_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b01, 1'b0, 8'h00});
        tick();
        chk("t1_rsp_off", 32'(bus.rsp_valid), 32'h0);
        chk("t1_reg3", 32'(regs[3]), 32'hA5);

        // 2: req1 read 0x03
        drive(2'b10, 2'b00, 16'h0300, 16'h0000);
        chk("t2_ready", 32'(bus.req_ready), 32'h2);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t2_strobe", {bus.rf_write, bus.rf_read, bus.rf_read_addr}, {2'b01, 8'h03});
        tick();
        tick();
        chk("t2_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 1'b0, 8'hA5});
        tick();

        // 3: both requesters continuously, six transactions
        snap_a = n_rsp0;
        snap_b = n_rsp1;
        drive(2'b11, 2'b11, 16'h0605, 16'h6B5A);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_grant%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            tick();
            tick();
            chk($sformatf("t3_rsp%0d", k), {bus.rsp_valid, bus.rsp_err},
                (k % 2 == 0) ? {2'b01, 1'b0} : {2'b10, 1'b0});
            tick();
        end
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        tick();
        chk("t3_cnt0", 32'(n_rsp0 - snap_a), 32'd3);
        chk("t3_cnt1", 32'(n_rsp1 - snap_b), 32'd3);
        chk("t3_regs", {regs[5], regs[6]}, {8'h5A, 8'h6B});

        // 4: out-of-range write 0x09 then read 0xFF
        snap_a = n_wr;
        snap_b = n_rd;
        drive(2'b01, 2'b01, 16'h0009, 16'h0077);
        chk("t4w_ready", 32'(bus.req_ready), 32'h1);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t4w_nostrobe", {bus.rf_write, bus.rf_read, bus.rf_write_addr}, {2'b00, 8'h06});
        tick();
        tick();
        chk("t4w_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b01, 1'b1, 8'h00});
        tick();
        chk("t4w_err_off", 32'(bus.rsp_err), 32'h0);
        drive(2'b01, 2'b00, 16'h00FF, 16'h0000);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t4r_nostrobe", {bus.rf_write, bus.rf_read}, 32'h0);
        tick();
        tick();
        chk("t4r_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b01, 1'b1, 8'h00});
        tick();
        chk("t4_no_rf_access", {16'(n_wr - snap_a), 16'(n_rd - snap_b)}, 32'h0);
        chk("t4_regs", {regs[0], regs[3], regs[5], regs[6]}, 32'h00A55A6B);

        // 5: reset during WAIT of a read
        drive(2'b01, 2'b00, 16'h0003, 16'h0000);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t5_strobe", {bus.rf_read, bus.rf_read_addr}, {1'b1, 8'h03});
        tick();
        snap_a = n_rsp0;
        reset = 1'b1;
        #1;
        chk("t5_rst_outs", {bus.rf_read_addr, bus.rf_write_addr, bus.rf_write_data,
                            bus.rsp_valid, bus.rsp_err, bus.rf_write, bus.rf_read}, 32'h0);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_no_rsp", 32'(n_rsp0 - snap_a), 32'h0);
        drive(2'b11, 2'b00, 16'h0100, 16'h0000);
        chk("t5_ready_after_rst", 32'(bus.req_ready), 32'h1);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("t5_read0", {bus.rf_read, bus.rf_read_addr}, {1'b1, 8'h00});
        tick();
        tick();
        chk("t5_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b01, 1'b0, 8'h00});
        tick();

        // 6: req1 pulses valid while busy, then drops it
        drive(2'b01, 2'b01, 16'h0002, 16'h0022);
        chk("t6_ready", 32'(bus.req_ready), 32'h1);
        tick();
        snap_a = n_rsp1;
        snap_b = n_rd;
        snap_c = n_wr;
        drive(2'b10, 2'b00, 16'h0100, 16'h0000);
        chk("t6_ready_busy", 32'(bus.req_ready), 32'h0);
        tick();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000);
        tick();
        chk("t6_rsp", {bus.rsp_valid, bus.rsp_err}, {2'b01, 1'b0});
        for (int i = 0; i < 5; i++) tick();
        chk("t6_quiet", {8'(n_rsp1 - snap_a), 8'(n_rd - snap_b), 8'(n_wr - snap_c)},
            {8'd0, 8'd0, 8'd1});
        chk("t6_reg2", 32'(regs[2]), 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
